// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with req/ack handshake and programmable wait states
// Ports: clk, rst_n (async active-low); request side req/we/byte_en/sign_ext/addr[15:0]/wdata[15:0];
// response side ack (one-cycle pulse), rdata[15:0] and err (held until next ack), busy (acceptance..ack).
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        byte_en,
    input  logic        sign_ext,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic we_q, be_q, se_q;
    logic [15:0] addr_q, wdata_q;
    logic [15:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [ADDR_WIDTH-1:0] idx;
    logic [15:0] word, rd_val, wr_val;
    logic [7:0] rbyte;
    logic bad, commit;

    assign idx    = addr_q[ADDR_WIDTH:1];
    assign bad    = (!be_q && addr_q[0]) || (addr_q[15:ADDR_WIDTH+1] != '0);
    assign word   = mem[idx];
    assign rbyte  = addr_q[0] ? word[15:8] : word[7:0];
    assign rd_val = be_q ? {(se_q ? {8{rbyte[7]}} : 8'h00), rbyte} : word;
    assign wr_val = !be_q ? wdata_q : addr_q[0] ? {wdata_q[7:0], word[7:0]} : {word[15:8], wdata_q[7:0]};
    // The access is performed on the edge leaving RESP, the same edge that raises ack.
    assign commit = state == RESP;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (req) begin
                state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                state_d = (cnt == 4'd0) ? RESP : WAIT;
                cnt_d   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 16'h0000;
            we_q    <= 1'b0;
            be_q    <= 1'b0;
            se_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ack   <= commit;
            busy  <= state_d != IDLE;
            err   <= commit ? bad : err;
            rdata <= !commit ? rdata : bad ? 16'h0000 : we_q ? rdata : rd_val;
            if (state == IDLE && req) begin
                we_q    <= we;
                be_q    <= byte_en;
                se_q    <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Array is intentionally not reset; a reset mid-transaction leaves state != RESP so nothing is written.
    always_ff @(posedge clk) begin
        if (rst_n && commit && we_q && !bad)
            mem[idx] <= wr_val;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench for data_mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances)
module tb_data_mem_responder;
    localparam int AW = 8;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0, we = 1'b0, byte_en = 1'b0, sign_ext = 1'b0;
    logic [15:0] addr = 16'h0, wdata = 16'h0;
    logic ack, err, busy;
    logic [15:0] rdata;
    logic req0 = 1'b0, we0 = 1'b0;
    logic [15:0] addr0 = 16'h0, wdata0 = 16'h0;
    logic ack0, err0, busy0;
    logic [15:0] rdata0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] mm [0:(1 << AW) - 1];
    logic [15:0] last_rd = 16'h0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .byte_en(byte_en), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .byte_en(1'b0), .sign_ext(1'b0),
        .addr(addr0), .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a plain array of words; errors, lanes and extension computed from the access rules.
    task automatic model(input logic w, b, s, input logic [15:0] a, d,
                         output logic [15:0] e_rd, output logic e_err);
        int i;
        logic [7:0] by;
        i = int'(a) / 2;
        e_err = (!b && a[0]) || (int'(a) >= 2 * (1 << AW));
        if (e_err) e_rd = 16'h0000;
        else if (w) begin
            if (!b) mm[i] = d;
            else if (a[0]) mm[i] = {d[7:0], mm[i][7:0]};
            else mm[i] = {mm[i][15:8], d[7:0]};
            e_rd = last_rd;
        end else begin
            by = a[0] ? mm[i][15:8] : mm[i][7:0];
            e_rd = !b ? mm[i] : s ? 16'($signed(by)) : {8'h00, by};
        end
        last_rd = e_rd;
    endtask

    task automatic txn(input logic w, b, s, input logic [15:0] a, d,
                       output logic [15:0] o_rd, output logic o_err);
        logic [15:0] e_rd;
        logic e_err;
        int lat;
        model(w, b, s, a, d, e_rd, e_err);
        @(negedge clk);
        req = 1'b1; we = w; byte_en = b; sign_ext = s; addr = a; wdata = d;
        @(posedge clk); #1;
        check("busy_after_accept", {15'b0, busy}, 16'd1);
        req = 1'b0; we = 1'($urandom); byte_en = 1'($urandom); sign_ext = 1'($urandom);
        addr = 16'($urandom); wdata = 16'($urandom);
        lat = 0;
        while (ack !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ack_latency", 16'(lat), 16'(WS + 1));
        check("busy_with_ack", {15'b0, busy}, 16'd0);
        check("rdata", rdata, e_rd);
        check("err", {15'b0, err}, {15'b0, e_err});
        o_rd = rdata;
        o_err = err;
    endtask

    initial begin
        logic [15:0] r, e_rd;
        logic e, e_err;
        logic [15:0] ba [3];
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", {15'b0, ack}, 16'd0);
        check("reset_err", {15'b0, err}, 16'd0);
        check("reset_busy", {15'b0, busy}, 16'd0);
        check("reset_rdata", rdata, 16'h0000);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < (1 << AW); i++) txn(1'b1, 1'b0, 1'b0, 16'(2 * i), 16'($urandom), r, e);

        txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, r, e);
        check("wr_beef_err", {15'b0, e}, 16'd0);
        txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, r, e);
        check("rd_beef", r, 16'hBEEF);
        txn(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0080, r, e);
        txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, r, e);
        check("rd_80ef", r, 16'h80EF);
        txn(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0, r, e);
        check("rd_byte_sext", r, 16'hFF80);
        txn(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0, r, e);
        check("rd_byte_zext", r, 16'h0080);
        txn(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, r, e);
        check("misaligned_err", {15'b0, e}, 16'd1);
        check("misaligned_rdata", r, 16'h0000);
        txn(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0, r, e);
        check("range_err", {15'b0, e}, 16'd1);
        txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, r, e);
        check("err_cleared", {15'b0, e}, 16'd0);
        check("legal_after_err", r, 16'h80EF);

        // req held high over three reads; addr changes right after each acceptance
        ba[0] = 16'h0040; ba[1] = 16'h0052; ba[2] = 16'h00A6;
        @(negedge clk);
        req = 1'b1; we = 1'b0; byte_en = 1'b0; addr = ba[0];
        @(posedge clk); #1;
        addr = ba[1];
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1;
            check("b2b_ack", {15'b0, ack}, {15'b0, t % 4 == 3});
            check("b2b_busy_ack", {15'b0, busy & ack}, 16'd0);
            if (t % 4 == 3) begin
                model(1'b0, 1'b0, 1'b0, ba[t / 4], 16'h0, e_rd, e_err);
                check("b2b_rdata", rdata, e_rd);
            end
            if (t == 4) addr = ba[2];
            if (t == 8) addr = 16'($urandom);
            if (t == 11) req = 1'b0;
        end
        check("b2b_idle_busy", {15'b0, busy}, 16'd0);

        txn(1'b1, 1'b0, 1'b0, 16'h0020, 16'h5555, r, e);
        @(negedge clk);
        req = 1'b1; we = 1'b1; byte_en = 1'b0; addr = 16'h0020; wdata = 16'h1234;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_ack", {15'b0, ack}, 16'd0);
            check("abort_busy", {15'b0, busy}, 16'd0);
        end
        check("abort_rdata", rdata, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        last_rd = 16'h0000;
        txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, r, e);
        check("abort_old_data", r, 16'h5555);

        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0004; wdata0 = 16'hA5A5;
        @(posedge clk); #1;
        check("ws0_accept_busy", {15'b0, busy0}, 16'd1);
        check("ws0_accept_ack", {15'b0, ack0}, 16'd0);
        we0 = 1'b0;
        @(posedge clk); #1;
        check("ws0_ack1", {15'b0, ack0}, 16'd1);
        check("ws0_ack1_busy", {15'b0, busy0}, 16'd0);
        @(posedge clk); #1;
        check("ws0_b2b_busy", {15'b0, busy0}, 16'd1);
        check("ws0_b2b_ack", {15'b0, ack0}, 16'd0);
        @(posedge clk); #1;
        check("ws0_ack2", {15'b0, ack0}, 16'd1);
        check("ws0_rdata", rdata0, 16'hA5A5);
        check("ws0_err", {15'b0, err0}, 16'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        check("ws0_idle_ack", {15'b0, ack0}, 16'd0);
        check("ws0_idle_busy", {15'b0, busy0}, 16'd0);

        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) a = a | (16'h0200 << $urandom_range(0, 6));
            txn(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), r, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data-memory request interface. The MEM stage is the initiator; this block is the memory that answers it.
- Accepts one request at a time over a req/ack handshake and inserts a programmable number of wait states.
- Performs 16-bit word or 8-bit byte reads and writes, with optional sign extension on byte loads.
- Reports misaligned and out-of-range accesses through an error flag that accompanies ack.

Parameters:
- ADDR_WIDTH, 8, number of word-address bits; the array holds 2**ADDR_WIDTH 16-bit words.
- WAIT_STATES, 2, number of extra cycles between acceptance and the response; range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request valid, held by the initiator until ack.
- we  in  1  1 = write, 0 = read.
- byte_en  in  1  1 = byte access, 0 = word access.
- sign_ext  in  1  byte read only: 1 = sign-extend, 0 = zero-extend.
- addr  in  16  byte address.
- wdata  in  16  write data; byte writes use wdata[7:0].
- ack  out  1  one-cycle response pulse.
- rdata  out  16  read data, valid while ack=1 and held until the next ack.
- err  out  1  error flag, valid with ack and held until the next ack.
- busy  out  1  high from acceptance until ack.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; ack, err and busy = 0; rdata = 16'h0000; wait counter = 0.
  - Memory array contents are not reset.
- State IDLE:
  - If req=1 at the edge, capture we, byte_en, sign_ext, addr and wdata. Request inputs are don't-care after capture.
  - Set busy=1.
  - If WAIT_STATES=0, go to RESP; otherwise go to WAIT with counter = WAIT_STATES-1.
- State WAIT: each edge decrements the counter; when the counter is 0, go to RESP.
- Entering RESP: the memory access commits on the same edge that raises ack.
  - ack=1 for exactly one cycle; busy=0; next state IDLE.
- Latency: with req accepted at edge N, ack is high in the cycle after edge N+WAIT_STATES+1.
  - With WAIT_STATES=2 and acceptance at edge 0, ack rises at edge 3.
  - Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- req is ignored outside IDLE. The initiator deasserts req in the cycle ack is high.
  - If req is still high at the edge leaving RESP, IDLE accepts it one edge later as a new request. This is the back-to-back case.
- Address decode:
  - word index = addr[ADDR_WIDTH:1]; byte select = addr[0]; little-endian, so addr[0]=0 selects bits [7:0].
- Error conditions:
  - A word access with addr[0]=1 is misaligned.
  - Any nonzero addr bit above ADDR_WIDTH is out of range.
  - On error: no memory write, rdata = 16'h0000, err=1 with ack.
  - A legal access clears err to 0 with its ack.
- Word read: rdata = mem[idx].
- Byte read:
  - rdata[7:0] = the selected byte.
  - rdata[15:8] = 8 copies of bit 7 of that byte when sign_ext=1, otherwise 8'h00.
- Word write: mem[idx] = wdata. rdata stays at its previous value, and ack and err are updated.
- Byte write: only the selected byte lane is replaced with wdata[7:0]; the other byte is preserved.
- Reset asserted while in WAIT: the pending access is abandoned, memory is unmodified, and no ack is issued.
- Read-after-write to the same address in consecutive transactions returns the new data. No internal forwarding is needed because accesses are serialized.

Test Plan:
- Reset, then word write 16'hBEEF to addr 16'h0010 → ack at cycle 3 after acceptance (WAIT_STATES=2), err=0. A word read of 16'h0010 then returns rdata=16'hBEEF.
- Byte write 8'h80 to addr 16'h0011 after the word above → a word read of 16'h0010 returns 16'h80EF.
  - A byte read of 16'h0011 with sign_ext=1 returns 16'hFF80; with sign_ext=0 it returns 16'h0080.
- Word read of addr 16'h0003 (misaligned) and of 16'h0200 (ADDR_WIDTH=8, out of range) → ack with err=1 and rdata=0. A following legal read clears err.
- Hold req high continuously over three reads → exactly one ack per WAIT_STATES+2 cycles, and busy is never high during ack.
  - Changing addr after acceptance does not alter the returned data.
- Assert rst_n=0 one cycle after accepting a word write of 16'h1234 to 16'h0020 → no ack, and a later read of 16'h0020 returns the old contents.
- WAIT_STATES=0 instance: accept at edge 0 → ack at edge 1, and a back-to-back request is accepted at edge 2.
